// File: rtl/neuromorph_pkg.sv
// Shared types and default constants for the neuromorph acquisition path.
package neuromorph_pkg;

  localparam int unsigned ADC_DATA_WIDTH    = 8;
  localparam int unsigned ADC_SAMPLE_PERIOD = 100;
  localparam int unsigned ADC_CONV_CYCLES   = 8;
  localparam int unsigned ADC_AVG_LOG2      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } adc_state_t;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/adc_sampler_if.sv
// Readback stream from adc_sampler to memory: word plus valid/ready handshake.
interface adc_sampler_if #(
  parameter int unsigned DATA_WIDTH = neuromorph_pkg::ADC_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] ADC_data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output ADC_data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  ADC_data,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/adc_avg_accum.sv
// Sums 2^AVG_LOG2 ADC captures and emits their truncated mean on the last one.
module adc_avg_accum
  import neuromorph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int unsigned AVG_LOG2   = ADC_AVG_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid
);

  localparam int unsigned ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned LAST  = (32'd1 << AVG_LOG2) - 32'd1;

  logic [ACC_W-1:0] acc_q, acc_d, sum_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_c;

  // The result is offered in the same cycle as the last sample arrives.
  always_comb begin
    sum_c        = acc_q + ACC_W'(din);
    last_c       = (cnt_q == CNT_W'(LAST));
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    result       = DATA_WIDTH'(sum_c >> AVG_LOG2);
    result_valid = 1'b0;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_en) begin
      if (last_c) begin
        acc_d        = '0;
        cnt_d        = '0;
        result_valid = 1'b1;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// Paced ADC acquisition: strobes conversions, averages captures and hands
// the decimated words to memory over a valid/ready register.
module adc_sampler
  import neuromorph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = ADC_DATA_WIDTH,
  parameter int unsigned SAMPLE_PERIOD = ADC_SAMPLE_PERIOD,
  parameter int unsigned CONV_CYCLES   = ADC_CONV_CYCLES,
  parameter int unsigned AVG_LOG2      = ADC_AVG_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] ADC_code,
  output logic                  adc_start,
  output logic                  overrun,
  input  logic                  clear_overrun,
  adc_sampler_if.master         mem_if
);

  localparam int unsigned PER_W  = cnt_width(SAMPLE_PERIOD);
  localparam int unsigned WAIT_W = cnt_width(CONV_CYCLES);

  if (SAMPLE_PERIOD <= CONV_CYCLES + 2) begin : g_bad_period
    $error("adc_sampler: SAMPLE_PERIOD must exceed CONV_CYCLES+2");
  end
  if (CONV_CYCLES < 1) begin : g_bad_conv
    $error("adc_sampler: CONV_CYCLES must be at least 1");
  end

  adc_state_t            state_q, state_d;
  logic [PER_W-1:0]      per_q, per_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  discard_q, discard_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic                  fire_c;
  logic                  sample_en_c;
  logic                  flush_c;
  logic                  drop_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  result_valid_c;

  // The strobe is registered, so the FSM is already in WAIT during the
  // strobe cycle; WAIT therefore spans CONV_CYCLES cycles including it.
  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    wait_d      = wait_q;
    discard_d   = discard_q;
    start_d     = 1'b0;
    sample_en_c = 1'b0;
    fire_c      = (state_q == IDLE) && en && (per_q == '0);

    // Phase zero waits for the FSM, so a re-enable during a discarded
    // conversion strobes as soon as the FSM is idle again.
    if (!en) begin
      per_d = '0;
    end else if (fire_c || (per_q != '0)) begin
      per_d = (per_q == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : per_q + PER_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (fire_c) begin
          state_d   = WAIT;
          start_d   = 1'b1;
          wait_d    = WAIT_W'(CONV_CYCLES - 1);
          discard_d = 1'b0;
        end
      end
      WAIT: begin
        discard_d = discard_q | ~en;
        if (wait_q == '0) begin
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      CAPTURE: begin
        sample_en_c = en & ~discard_q;
        discard_d   = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign flush_c = ~en;

  adc_avg_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_LOG2   (AVG_LOG2)
  ) u_accum (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en_c),
    .flush        (flush_c),
    .din          (ADC_code),
    .result       (result_c),
    .result_valid (result_valid_c)
  );

  // Output word register: a new result may replace a word leaving this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    drop_c    = result_valid_c & valid_q & ~mem_if.data_ready;

    if (result_valid_c && !drop_c) begin
      data_d  = result_c;
      valid_d = 1'b1;
    end else if (valid_q && mem_if.data_ready) begin
      valid_d = 1'b0;
    end

    if (drop_c) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      per_q     <= '0;
      wait_q    <= '0;
      discard_q <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      wait_q    <= wait_d;
      discard_q <= discard_d;
      start_q   <= start_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_start         = start_q;
  assign overrun           = overrun_q;
  assign mem_if.ADC_data   = data_q;
  assign mem_if.data_valid = valid_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: directed group table, handshake/enable/reset
// sequences, and a randomized run against a behavioural model.
module tb_adc_sampler;

  localparam int unsigned P = 16;
  localparam int unsigned C = 4;
  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] ADC_code = 8'd0;
  logic       adc_start;
  logic       overrun;

  adc_sampler_if #(.DATA_WIDTH(8)) mem_if ();

  adc_sampler #(
    .DATA_WIDTH    (8),
    .SAMPLE_PERIOD (P),
    .CONV_CYCLES   (C),
    .AVG_LOG2      (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .ADC_code      (ADC_code),
    .adc_start     (adc_start),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .mem_if        (mem_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: strobe times, a list of kept codes per group, and
  // the output word with its handshake.
  int         m_cyc, m_last, m_cur;
  bit         m_pend, m_ok, m_fresh, m_start, m_valid, m_ovr;
  logic [7:0] m_data;
  int         m_grp[$];

  task automatic model_reset();
    m_cyc = 0; m_last = -1000; m_cur = -1;
    m_pend = 0; m_ok = 0; m_fresh = 1;
    m_start = 0; m_valid = 0; m_ovr = 0; m_data = 8'd0;
    m_grp.delete();
  endtask

  task automatic model_edge(input bit e, input logic [7:0] code, input bit rdy, input bit clr);
    int         n = m_cyc;
    int         s = 0;
    bit         res_ok = 0;
    bit         drop;
    logic [7:0] res = 8'd0;
    if (m_pend && n == m_last + int'(C) + 1) begin
      m_pend = 0;
      if (e && m_ok) begin
        m_grp.push_back(int'(code));
        if (m_grp.size() == N) begin
          foreach (m_grp[i]) s += m_grp[i];
          res = 8'(s / int'(N));
          res_ok = 1;
          m_grp.delete();
        end
      end
    end
    if (!e) begin
      m_grp.delete();
      m_ok = 0;
      m_fresh = 1;
    end
    m_start = 0;
    if (e && n > m_last + int'(C) + 1 && (m_fresh || n == m_last + int'(P))) begin
      m_start = 1; m_last = n; m_pend = 1; m_ok = 1; m_fresh = 0;
    end
    drop = res_ok && m_valid && !rdy;
    if (res_ok && !drop) begin
      m_data = res;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
    m_cur = n;
    m_cyc = n + 1;
  endtask

  // One clock: drive at the falling edge, sample just after the rising edge.
  task automatic step(input bit e, input logic [7:0] code, input bit rdy, input bit clr);
    @(negedge clk);
    en = e; ADC_code = code; mem_if.data_ready = rdy; clear_overrun = clr;
    @(posedge clk);
    model_edge(e, code, rdy, clr);
    #1;
    check("mdl_start", 32'(adc_start), 32'(m_start));
    check("mdl_valid", 32'(mem_if.data_valid), 32'(m_valid));
    check("mdl_data", 32'(mem_if.ADC_data), 32'(m_data));
    check("mdl_overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic hit_reset();
    #2;
    reset = 1'b0; en = 1'b0; mem_if.data_ready = 1'b0; clear_overrun = 1'b0;
    #1;
    check("rst_start", 32'(adc_start), 32'd0);
    check("rst_data", 32'(mem_if.ADC_data), 32'd0);
    check("rst_valid", 32'(mem_if.data_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0][7:0] code;
    logic [7:0]      avg;
  } grp_vec_t;

  grp_vec_t   vecs [6];
  logic [7:0] code_v;
  bit         e_v;
  int         rdy_pct;

  initial begin
    vecs[0] = '{code: {8'd41, 8'd30, 8'd20, 8'd10}, avg: 8'd25};
    vecs[1] = '{code: {8'd255, 8'd255, 8'd255, 8'd255}, avg: 8'd255};
    vecs[2] = '{code: {8'd3, 8'd0, 8'd0, 8'd0}, avg: 8'd0};
    vecs[3] = '{code: {8'd4, 8'd3, 8'd2, 8'd1}, avg: 8'd2};
    vecs[4] = '{code: {8'd6, 8'd7, 8'd7, 8'd7}, avg: 8'd6};
    vecs[5] = '{code: {8'd255, 8'd255, 8'd255, 8'd0}, avg: 8'd191};
    mem_if.data_ready = 1'b0;
    model_reset();

    // Group table: codes only on the capture edges, junk elsewhere.
    for (int v = 0; v < 6; v++) begin
      hit_reset();
      for (int c = 0; c <= 56; c++) begin
        if ((c % int'(P)) == int'(C) + 1 && c / int'(P) < 4) code_v = vecs[v].code[c / int'(P)];
        else code_v = 8'($urandom);
        step(1'b1, code_v, 1'b1, 1'b0);
        check("tbl_start", 32'(adc_start), 32'((c % int'(P)) == 0));
        check("tbl_valid", 32'(mem_if.data_valid), 32'(c == 53));
        if (c == 53) check("tbl_data", 32'(mem_if.ADC_data), 32'(vecs[v].avg));
      end
    end

    // Overrun: two groups with ready low, then clear and drain.
    hit_reset();
    for (int c = 0; c <= 118; c++) step(1'b1, (c < 64) ? 8'd100 : 8'd200, 1'b0, 1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_hold_valid", 32'(mem_if.data_valid), 32'd1);
    check("ovr_hold_data", 32'(mem_if.ADC_data), 32'd100);
    step(1'b1, 8'd0, 1'b0, 1'b1);
    check("ovr_clear", 32'(overrun), 32'd0);
    step(1'b1, 8'd0, 1'b1, 1'b0);
    check("ovr_drain_valid", 32'(mem_if.data_valid), 32'd0);
    check("ovr_drain_data", 32'(mem_if.ADC_data), 32'd100);

    // Ready rises in the cycle the next result lands.
    hit_reset();
    for (int c = 0; c <= 116; c++) step(1'b1, (c < 64) ? 8'd100 : 8'd200, 1'b0, 1'b0);
    check("b2b_pre_valid", 32'(mem_if.data_valid), 32'd1);
    step(1'b1, 8'd200, 1'b1, 1'b0);
    check("b2b_valid", 32'(mem_if.data_valid), 32'd1);
    check("b2b_data", 32'(mem_if.ADC_data), 32'd200);
    check("b2b_overrun", 32'(overrun), 32'd0);
    step(1'b1, 8'd0, 1'b1, 1'b0);
    check("b2b_post_valid", 32'(mem_if.data_valid), 32'd0);

    // Enable dropped during the second conversion, then re-enabled.
    hit_reset();
    for (int c = 0; c <= 17; c++) step(1'b1, 8'd50, 1'b1, 1'b0);
    for (int c = 18; c <= 79; c++) begin
      step(1'b0, 8'd50, 1'b1, 1'b0);
      check("dis_start", 32'(adc_start), 32'd0);
      check("dis_valid", 32'(mem_if.data_valid), 32'd0);
    end
    for (int c = 80; c <= 134; c++) begin
      step(1'b1, 8'd8, 1'b1, 1'b0);
      if (c == 80) check("reen_start", 32'(adc_start), 32'd1);
      check("reen_valid", 32'(mem_if.data_valid), 32'(c == 133));
      if (c == 133) check("reen_data", 32'(mem_if.ADC_data), 32'd8);
    end

    // Reset with every output active, then mid-group at cycle 21.
    hit_reset();
    for (int c = 0; c <= 128; c++) step(1'b1, (c < 64) ? 8'd100 : 8'd200, 1'b0, 1'b0);
    check("pre_rst_start", 32'(adc_start), 32'd1);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    hit_reset();
    for (int c = 0; c <= 21; c++) step(1'b1, 8'd77, 1'b1, 1'b0);
    hit_reset();
    for (int c = 0; c <= 54; c++) begin
      step(1'b1, 8'd60, 1'b1, 1'b0);
      if (c == 0) check("rel_start", 32'(adc_start), 32'd1);
      check("rel_valid", 32'(mem_if.data_valid), 32'(c == 53));
      if (c == 53) check("rel_data", 32'(mem_if.ADC_data), 32'd60);
    end

    // Randomized run against the model.
    hit_reset();
    e_v = 1'b1;
    rdy_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 256) == 0) begin
        case ($urandom_range(0, 3))
          0: rdy_pct = 0;
          1: rdy_pct = 3;
          2: rdy_pct = 50;
          default: rdy_pct = 100;
        endcase
      end
      if (e_v && $urandom_range(0, 999) < 3) e_v = 1'b0;
      else if (!e_v && $urandom_range(0, 999) < 30) e_v = 1'b1;
      step(e_v, 8'($urandom), int'($urandom_range(0, 99)) < rdy_pct,
           $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
